// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared register map, bit positions and TX FSM encoding for
//                the uart_ctrl MMIO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

  // Register byte offsets
  localparam logic [3:0] C_ADDR_CTRL   = 4'h0;
  localparam logic [3:0] C_ADDR_STATUS = 4'h4;
  localparam logic [3:0] C_ADDR_TXDATA = 4'h8;
  localparam logic [3:0] C_ADDR_RXDATA = 4'hC;

  // CTRL bit positions (flush bits are write-1 pulses, never stored)
  localparam int C_CTRL_TX_EN      = 0;
  localparam int C_CTRL_RX_EN      = 1;
  localparam int C_CTRL_IRQ_RX_EN  = 2;
  localparam int C_CTRL_IRQ_TXE_EN = 3;
  localparam int C_CTRL_TX_FLUSH   = 4;
  localparam int C_CTRL_RX_FLUSH   = 5;
  localparam int C_CTRL_W          = 4;

  // STATUS bit positions
  localparam int C_ST_TX_FULL      = 0;
  localparam int C_ST_TX_EMPTY     = 1;
  localparam int C_ST_RX_FULL      = 2;
  localparam int C_ST_RX_EMPTY     = 3;
  localparam int C_ST_RX_OVERRUN   = 4;
  localparam int C_ST_TX_BUSY      = 5;
  localparam int C_ST_TX_DROP      = 6;
  localparam int C_ST_TX_COUNT_LSB = 8;
  localparam int C_ST_RX_COUNT_LSB = 16;

  // RXDATA read value when the RX FIFO is empty
  localparam logic [31:0] C_RXDATA_EMPTY = 32'h0000_0100;

  // TX sequencing states
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/uart_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with extra-MSB pointers, flush and an
//                occupancy count. Pop on empty is ignored; push on full is
//                accepted only when a pop frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Equal pointers mean empty; equal index with differing MSB means full
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count    = r_wr_ptr - r_rd_ptr;
  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer update; flush overrides any concurrent push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl
//  Description : MMIO controller for uart_core. Feeds the core from a TX FIFO
//                through a two-state handshake FSM, drains received bytes
//                into an RX FIFO and raises a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mmio_addr,
  input  logic                  mmio_wr_en,
  input  logic                  mmio_rd_en,
  input  logic [31:0]           mmio_wdata,
  output logic [31:0]           mmio_rdata,
  output logic [DATA_WIDTH-1:0] uart_data_in,
  output logic                  uart_data_in_valid,
  input  logic                  uart_data_in_ready,
  input  logic [DATA_WIDTH-1:0] uart_data_out,
  input  logic                  uart_data_out_valid,
  output logic                  uart_data_out_ready,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Registered state
  logic [C_CTRL_W-1:0]   r_ctrl;
  logic                  r_rx_overrun;
  logic                  r_tx_drop;
  tx_state_t             r_state;

  // Register decode strobes
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_wr_txdata;
  logic                  w_rd_rxdata;

  // FIFO interfaces
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_flush;
  logic [DATA_WIDTH-1:0] w_tx_head;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic [CW-1:0]         w_tx_count;

  logic                  w_rx_push;
  logic                  w_rx_pop;
  logic                  w_rx_flush;
  logic [DATA_WIDTH-1:0] w_rx_head;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic [CW-1:0]         w_rx_count;

  logic                  w_tx_busy;
  logic                  w_handshake;
  logic                  w_rx_overrun_set;
  logic                  w_tx_drop_set;
  logic [31:0]           w_status;
  logic                  w_unused;

  assign w_wr_ctrl   = mmio_wr_en && (mmio_addr == C_ADDR_CTRL);
  assign w_wr_status = mmio_wr_en && (mmio_addr == C_ADDR_STATUS);
  assign w_wr_txdata = mmio_wr_en && (mmio_addr == C_ADDR_TXDATA);
  assign w_rd_rxdata = mmio_rd_en && (mmio_addr == C_ADDR_RXDATA);

  assign w_tx_flush  = w_wr_ctrl && mmio_wdata[C_CTRL_TX_FLUSH];
  assign w_rx_flush  = w_wr_ctrl && mmio_wdata[C_CTRL_RX_FLUSH];

  assign w_tx_push   = w_wr_txdata;
  assign w_tx_busy   = (r_state != TX_IDLE);
  assign w_handshake = uart_data_in_valid && uart_data_in_ready;

  // RX acceptance follows rx_en directly so the core sees it the same cycle
  assign uart_data_out_ready = r_ctrl[C_CTRL_RX_EN];
  assign w_rx_push           = uart_data_out_valid && uart_data_out_ready;
  assign w_rx_pop            = w_rd_rxdata && !w_rx_empty;

  // A full-FIFO push only loses data when nothing is leaving that cycle
  assign w_rx_overrun_set = w_rx_push && w_rx_full && !w_rx_pop && !w_rx_flush;
  assign w_tx_drop_set    = w_tx_push && w_tx_full && !w_tx_pop && !w_tx_flush;

  // Upper write-data bits have no register behind them
  assign w_unused = ^mmio_wdata[31:DATA_WIDTH];

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_tx_push),
    .push_data (mmio_wdata[DATA_WIDTH-1:0]),
    .pop       (w_tx_pop),
    .flush     (w_tx_flush),
    .pop_data  (w_tx_head),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .count     (w_tx_count)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_rx_push),
    .push_data (uart_data_out),
    .pop       (w_rx_pop),
    .flush     (w_rx_flush),
    .pop_data  (w_rx_head),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .count     (w_rx_count)
  );

  // TX FIFO pop: load from IDLE, or chain the next byte on a SEND handshake
  always_comb begin
    w_tx_pop = 1'b0;
    case (r_state)
      TX_IDLE: w_tx_pop = r_ctrl[C_CTRL_TX_EN] && !w_tx_empty;
      TX_SEND: w_tx_pop = w_handshake && r_ctrl[C_CTRL_TX_EN] && !w_tx_empty;
      default: w_tx_pop = 1'b0;
    endcase
  end

  // TX FSM: byte and valid are held stable until the core accepts them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= TX_IDLE;
      uart_data_in       <= '0;
      uart_data_in_valid <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            uart_data_in       <= w_tx_head;
            uart_data_in_valid <= 1'b1;
            r_state            <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (w_handshake) begin
            if (w_tx_pop) begin
              uart_data_in <= w_tx_head;
            end else begin
              uart_data_in_valid <= 1'b0;
              r_state            <= TX_IDLE;
            end
          end
        end
        default: begin
          r_state            <= TX_IDLE;
          uart_data_in_valid <= 1'b0;
        end
      endcase
    end
  end

  // CTRL storage and sticky STATUS flags (a new event beats a W1C clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl       <= '0;
      r_rx_overrun <= 1'b0;
      r_tx_drop    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= mmio_wdata[C_CTRL_W-1:0];
      r_rx_overrun <= w_rx_overrun_set ||
                      (r_rx_overrun && !(w_wr_status && mmio_wdata[C_ST_RX_OVERRUN]));
      r_tx_drop    <= w_tx_drop_set ||
                      (r_tx_drop && !(w_wr_status && mmio_wdata[C_ST_TX_DROP]));
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status                               = '0;
    w_status[C_ST_TX_FULL]                 = w_tx_full;
    w_status[C_ST_TX_EMPTY]                = w_tx_empty;
    w_status[C_ST_RX_FULL]                 = w_rx_full;
    w_status[C_ST_RX_EMPTY]                = w_rx_empty;
    w_status[C_ST_RX_OVERRUN]              = r_rx_overrun;
    w_status[C_ST_TX_BUSY]                 = w_tx_busy;
    w_status[C_ST_TX_DROP]                 = r_tx_drop;
    w_status[C_ST_TX_COUNT_LSB +: CW]      = w_tx_count;
    w_status[C_ST_RX_COUNT_LSB +: CW]      = w_rx_count;
  end

  // Read data: captured on the read strobe and held until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_rdata <= '0;
    end else if (mmio_rd_en) begin
      case (mmio_addr)
        C_ADDR_CTRL:   mmio_rdata <= 32'(r_ctrl);
        C_ADDR_STATUS: mmio_rdata <= w_status;
        C_ADDR_RXDATA: mmio_rdata <= w_rx_empty ? C_RXDATA_EMPTY : 32'(w_rx_head);
        default:       mmio_rdata <= '0;
      endcase
    end
  end

  // Level interrupt, registered one cycle behind its causes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (r_ctrl[C_CTRL_IRQ_RX_EN] && !w_rx_empty) ||
             (r_ctrl[C_CTRL_IRQ_TXE_EN] && w_tx_empty && !w_tx_busy);
    end
  end

endmodule : uart_ctrl
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_ctrl
//  Description : Self-checking bench for uart_ctrl: register vector tables
//                plus hand-written TX/RX/irq/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_TXD  = 4'h8;
  localparam logic [3:0] A_RXD  = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mmio_addr = '0;
  logic        mmio_wr_en = 1'b0;
  logic        mmio_rd_en = 1'b0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_data_in;
  logic        uart_data_in_valid;
  logic        uart_data_in_ready = 1'b0;
  logic [7:0]  uart_data_out = '0;
  logic        uart_data_out_valid = 1'b0;
  logic        uart_data_out_ready;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
    string       name;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] txq[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  uart_ctrl #(.FIFO_DEPTH(16), .DATA_WIDTH(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mmio_addr           (mmio_addr),
    .mmio_wr_en          (mmio_wr_en),
    .mmio_rd_en          (mmio_rd_en),
    .mmio_wdata          (mmio_wdata),
    .mmio_rdata          (mmio_rdata),
    .uart_data_in        (uart_data_in),
    .uart_data_in_valid  (uart_data_in_valid),
    .uart_data_in_ready  (uart_data_in_ready),
    .uart_data_out       (uart_data_out),
    .uart_data_out_valid (uart_data_out_valid),
    .uart_data_out_ready (uart_data_out_ready),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Collect accepted TX bytes and flag any change while stalled
  always @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("tx_hold_stable", {23'd0, uart_data_in_valid, uart_data_in}, {23'd0, 1'b1, prev_data});
      if (uart_data_in_valid && uart_data_in_ready) txq.push_back(uart_data_in);
      prev_stall <= uart_data_in_valid && !uart_data_in_ready;
      prev_data  <= uart_data_in;
    end
  end

  task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
    mmio_addr = a; mmio_wdata = d; mmio_wr_en = 1'b1;
    @(negedge clk);
    mmio_wr_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [3:0] a, output logic [31:0] d);
    mmio_addr = a; mmio_rd_en = 1'b1;
    @(negedge clk);
    mmio_rd_en = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic add_wr(input logic [3:0] a, input logic [31:0] d);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.mask = '1; v.name = "wr";
    vq.push_back(v);
  endtask

  task automatic add_rd(input string n, input logic [3:0] a, input logic [31:0] e,
                        input logic [31:0] m);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = e; v.mask = m; v.name = n;
    vq.push_back(v);
  endtask

  task automatic run_vecs();
    logic [31:0] d;
    foreach (vq[i]) begin
      if (vq[i].wr) mmio_write(vq[i].addr, vq[i].data);
      else begin
        mmio_read(vq[i].addr, d);
        check(vq[i].name, d & vq[i].mask, vq[i].data);
      end
    end
    vq.delete();
  endtask

  task automatic rx_drive(input logic [7:0] b);
    uart_data_out = b; uart_data_out_valid = 1'b1;
    @(negedge clk);
    uart_data_out_valid = 1'b0;
  endtask

  // Wait for n accepted bytes and an idle output, then confirm nothing extra
  task automatic wait_txq(input string n, input int cnt);
    int cyc = 0;
    while (!(txq.size() >= cnt && !uart_data_in_valid) && cyc < 400) begin
      @(negedge clk); cyc++;
    end
    check({n, "_done"}, 32'(cyc < 400), 32'd1);
    repeat (4) @(negedge clk);
    check({n, "_count"}, 32'(txq.size()), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_rdata", mmio_rdata, 32'd0);
    check("rst_outs", {28'd0, uart_data_in_valid, uart_data_out_ready, irq, |uart_data_in}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    add_rd("rst_ctrl", A_CTRL, 32'h0, '1);
    add_rd("rst_status", A_STAT, 32'h0000_000A, '1);
    run_vecs();

    // ---------------- 1: basic TX ----------------
    mmio_write(A_CTRL, 32'h1);
    mmio_write(A_TXD, 32'h41);
    mmio_write(A_TXD, 32'h42);
    mmio_write(A_TXD, 32'h43);
    repeat (2) @(negedge clk);
    check("t1_first_valid", {23'd0, uart_data_in_valid, uart_data_in}, 32'h141);
    uart_data_in_ready = 1'b1;
    wait_txq("t1", 3);
    uart_data_in_ready = 1'b0;
    check("t1_b0", 32'(txq.size() > 0 ? txq[0] : 8'hFF), 32'h41);
    check("t1_b1", 32'(txq.size() > 1 ? txq[1] : 8'hFF), 32'h42);
    check("t1_b2", 32'(txq.size() > 2 ? txq[2] : 8'hFF), 32'h43);
    add_rd("t1_status", A_STAT, 32'h02, 32'h22);
    run_vecs();

    // ---------------- 2: RX fill, overrun, full pop+push ----------------
    mmio_write(A_CTRL, 32'h2);
    for (int i = 0; i < 16; i++) rx_drive(8'(i));
    rx_drive(8'hAA);
    add_rd("t2_status_full", A_STAT, 32'h0010_0016, '1);
    add_wr(A_STAT, 32'h10);
    add_rd("t2_status_w1c", A_STAT, 32'h0010_0006, '1);
    run_vecs();
    uart_data_out = 8'hBB; uart_data_out_valid = 1'b1;
    mmio_addr = A_RXD; mmio_rd_en = 1'b1;
    @(negedge clk);
    uart_data_out_valid = 1'b0; mmio_rd_en = 1'b0;
    check("t2_popush_rd", mmio_rdata, 32'h00);
    add_rd("t2_status_popush", A_STAT, 32'h0010_0006, '1);
    for (int i = 1; i < 16; i++) add_rd("t2_rxdata", A_RXD, 32'(i), '1);
    add_rd("t2_rxdata_last", A_RXD, 32'hBB, '1);
    add_rd("t2_rxdata_empty", A_RXD, 32'h100, '1);
    add_rd("t2_rxdata_empty2", A_RXD, 32'h100, '1);
    add_rd("t2_status_end", A_STAT, 32'h0000_000A, '1);
    run_vecs();

    // ---------------- 3: TX drop and bulk send ----------------
    add_wr(A_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) add_wr(A_TXD, 32'h80 + 32'(i));
    add_rd("t3_status_drop", A_STAT, 32'h0000_1049, '1);
    add_wr(A_STAT, 32'h40);
    add_rd("t3_status_w1c", A_STAT, 32'h0000_1009, '1);
    add_rd("t3_txdata_rd", A_TXD, 32'h0, '1);
    add_rd("t3_unmapped_rd", 4'h2, 32'h0, '1);
    run_vecs();
    txq.delete();
    uart_data_in_ready = 1'b1;
    mmio_write(A_CTRL, 32'h1);
    wait_txq("t3", 16);
    uart_data_in_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      check("t3_byte", 32'(txq.size() > i ? txq[i] : 8'hFF), 32'h80 + 32'(i));

    // ---------------- 4: flush while sending ----------------
    txq.delete();
    mmio_write(A_TXD, 32'h55);
    mmio_write(A_TXD, 32'h66);
    repeat (2) @(negedge clk);
    mmio_write(A_CTRL, 32'h11);
    add_rd("t4_status_flushed", A_STAT, 32'h22, 32'h1F23);
    add_rd("t4_ctrl_rb", A_CTRL, 32'h1, '1);
    run_vecs();
    check("t4_held", {23'd0, uart_data_in_valid, uart_data_in}, 32'h155);
    uart_data_in_ready = 1'b1;
    wait_txq("t4", 1);
    uart_data_in_ready = 1'b0;
    check("t4_byte", 32'(txq.size() > 0 ? txq[0] : 8'hFF), 32'h55);
    add_rd("t4_status_idle", A_STAT, 32'h02, 32'h22);
    run_vecs();

    // ---------------- 5: interrupt causes ----------------
    txq.delete();
    mmio_write(A_CTRL, 32'h0F);
    repeat (2) @(negedge clk);
    check("t5_irq_txe", 32'(irq), 32'd1);
    mmio_write(A_TXD, 32'h33);
    repeat (3) @(negedge clk);
    check("t5_irq_busy", {30'd0, irq, uart_data_in_valid}, 32'h1);
    rx_drive(8'h7E);
    repeat (2) @(negedge clk);
    check("t5_irq_rx", 32'(irq), 32'd1);
    uart_data_in_ready = 1'b1;
    wait_txq("t5", 1);
    uart_data_in_ready = 1'b0;
    mmio_read(A_RXD, d);
    check("t5_rxdata", d, 32'h7E);
    repeat (2) @(negedge clk);
    check("t5_irq_txe_only", 32'(irq), 32'd1);
    mmio_write(A_CTRL, 32'h07);
    repeat (2) @(negedge clk);
    check("t5_irq_off", 32'(irq), 32'd0);

    // ---------------- 6: reset mid-transfer ----------------
    mmio_write(A_CTRL, 32'h3);
    for (int i = 0; i < 9; i++) mmio_write(A_TXD, 32'hC0 + 32'(i));
    repeat (2) @(negedge clk);
    check("t6_sending", {23'd0, uart_data_in_valid, uart_data_in}, 32'h1C0);
    rst = 1'b1;
    #1;
    check("t6_async_outs", {28'd0, uart_data_in_valid, uart_data_out_ready, irq, |uart_data_in}, 32'd0);
    check("t6_async_rdata", mmio_rdata, 32'd0);
    txq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    add_rd("t6_ctrl", A_CTRL, 32'h0, '1);
    add_rd("t6_status", A_STAT, 32'h0000_000A, '1);
    run_vecs();
    uart_data_in_ready = 1'b1;
    repeat (20) @(negedge clk);
    uart_data_in_ready = 1'b0;
    check("t6_no_spurious", {31'(txq.size()), uart_data_in_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_ctrl
`default_nettype wire

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Memory-mapped controller that sequences uart_core for the CPU.
- Owns a TX FIFO and an RX FIFO, and drives the uart_core data_in ready/valid handshake from the TX FIFO.
- Drains uart_core data_out into the RX FIFO.
- Exposes CTRL, STATUS, TXDATA and RXDATA registers plus a level interrupt.
- Sits between the core MMIO decode and uart_core; replaces the start_tx-triggered burst sequencing.

Parameters:
FIFO_DEPTH, 16, entries per FIFO (power of two, >=2)
DATA_WIDTH, 8, UART character width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mmio_addr  in  4  byte offset: 0x0 CTRL, 0x4 STATUS, 0x8 TXDATA, 0xC RXDATA
mmio_wr_en  in  1  write strobe, one cycle
mmio_rd_en  in  1  read strobe, one cycle
mmio_wdata  in  32  write data
mmio_rdata  out  32  read data, registered
uart_data_in  out  8  byte to uart_core
uart_data_in_valid  out  1  byte valid
uart_data_in_ready  in  1  uart_core can accept
uart_data_out  in  8  byte from uart_core
uart_data_out_valid  in  1  received byte valid
uart_data_out_ready  out  1  controller accepts byte
irq  out  1  level interrupt, registered

Behaviour:
- Reset (async, rst=1):
  - CTRL=0, FIFOs empty, sticky flags 0, TX FSM=IDLE.
  - mmio_rdata=0, uart_data_in=0, uart_data_in_valid=0, uart_data_out_ready=0, irq=0.
  - Asserting rst mid-transfer abandons the byte; no recovery handshake.
- CTRL (RW) bits:
  - [0] tx_en, [1] rx_en, [2] irq_rx_en, [3] irq_txe_en.
  - [4] tx_flush and [5] rx_flush are write-1, self-clearing, and read back 0.
- STATUS (RO except W1C) bits:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [5] tx_busy (FSM != IDLE).
  - [4] rx_overrun and [6] tx_drop are sticky; write 1 clears.
  - [12:8] tx_count, [20:16] rx_count (0..FIFO_DEPTH).
- TXDATA (WO): write pushes wdata[7:0]. If the FIFO is full, the byte is dropped and tx_drop is set. Reads return 0.
- RXDATA (RO):
  - [7:0] head byte, [8] empty flag.
  - A read when non-empty pops. A read when empty returns 0x100 with no pop.
- Read latency: mmio_rdata is valid the cycle after mmio_rd_en and holds its value until the next read. Unmapped offsets read 0; writes to them are ignored.
- TX FSM:
  - IDLE: if tx_en && !tx_empty, pop head into the uart_data_in register and set valid -> SEND.
  - SEND: hold uart_data_in and valid stable until valid&&ready. On handshake, if tx_en && !tx_empty, pop the next byte in the same cycle and stay in SEND (back-to-back); else clear valid -> IDLE.
  - Clearing tx_en in SEND does not withdraw the current byte; the FSM finishes it, then stays IDLE.
  - tx_flush empties the FIFO only; a byte already in SEND completes.
- RX:
  - uart_data_out_ready = rx_en (combinational from the CTRL reg).
  - On valid&&ready, push. If the FIFO is full and no pop occurs this cycle, discard the byte and set rx_overrun.
  - If an RXDATA pop and a push land in the same cycle on a full FIFO, both are accepted, count is unchanged, and there is no overrun.
  - rx_flush empties the FIFO. A flush coinciding with a push leaves the FIFO empty (flush wins).
- FIFO rules:
  - Pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty. Wrap-around is natural modulo.
  - Simultaneous push and pop on an empty FIFO: the push is stored and the pop has no effect.
  - An MMIO push to TX in the same cycle as an FSM pop is allowed.
- irq (registered, one cycle after cause) = (irq_rx_en && !rx_empty) || (irq_txe_en && tx_empty && !tx_busy).

Decomposition:
- Shared package/include uart_ctrl_pkg holds:
  - register offsets;
  - CTRL/STATUS bit positions;
  - TX FSM state encodings (IDLE=0, SEND=1);
  - RXDATA empty-flag constant 0x100.
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, flush, full, empty, count) is instantiated twice.
- uart_ctrl contains register decode, TX FSM and irq logic only.

Test Plan:
1. Reset, then write CTRL=0x1 and TXDATA 0x41, 0x42, 0x43 -> uart_data_in shows 0x41, 0x42, 0x43 in order, valid held until each ready, STATUS.tx_empty=1 and tx_busy=0 after the last handshake.
2. rx_en=1; drive 16 bytes 0x00..0x0F then 0xAA with no reads -> rx_count=16, rx_full=1, rx_overrun=1, RXDATA reads 0x00..0x0F in order, then 0x100.
3. tx_en=0; write 17 bytes -> tx_count=16, tx_drop=1. Write STATUS bit6=1 -> tx_drop=0. Set tx_en -> exactly 16 bytes transmitted.
4. Hold uart_data_in_ready=0 in SEND with byte 0x55, then write tx_flush -> 0x55 still delivered on ready, no further bytes, FSM returns to IDLE.
5. CTRL=0x0F with both FIFOs empty -> irq=1 (TX-empty cause). Push one TX byte -> irq drops while busy. Receive 0x7E -> irq=1. Read RXDATA -> 0x7E, and with TX done irq remains 1 via the TX-empty cause only.
6. Assert rst while in SEND with 8 bytes queued -> valid=0, counts=0, CTRL=0 immediately. After release, no spurious handshake.
